// File: rtl/ads1281_result_avg_pkg.sv
// Shared constants and FSM state type for the ADS1281 result averager.
package ads1281_result_avg_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 24;
    localparam int unsigned MAX_LOG2_DEF   = 7;
    localparam int unsigned ACC_WIDTH_DEF  = DATA_WIDTH_DEF + MAX_LOG2_DEF;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    // Accumulator holds up to 2^max_log2 full-scale samples without overflow.
    function automatic int unsigned acc_width(input int unsigned dw, input int unsigned ml);
        return dw + ml;
    endfunction

endpackage

// File: rtl/ads1281_result_avg_acc.sv
// Accumulate / round / shift datapath of the result averager.
// Define ADS1281_RESULT_AVG_ROUND_EN for round-half-up; otherwise the shift truncates.
module ads1281_result_avg_acc
    import ads1281_result_avg_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned MAX_LOG2   = MAX_LOG2_DEF
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  first_i,
    input  logic                  upd_i,
    input  logic                  clr_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic [2:0]            shift_i,
    output logic [DATA_WIDTH-1:0] result_o
);

    localparam int unsigned ACC_W = acc_width(DATA_WIDTH, MAX_LOG2);

    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [ACC_W-1:0] ext, base, sum, biased, shifted;
    logic                    unused_hi;

    always_comb begin
        ext  = {{MAX_LOG2{data_i[DATA_WIDTH-1]}}, data_i};
        // A new block starts from zero even if a stale partial sum is still held.
        base = first_i ? '0 : acc_q;
        sum  = base + ext;
`ifdef ADS1281_RESULT_AVG_ROUND_EN
        biased = (shift_i != 3'd0) ? sum + (ACC_W'(1) << (shift_i - 3'd1)) : sum;
`else
        biased = sum;
`endif
        shifted   = biased >>> shift_i;
        result_o  = shifted[DATA_WIDTH-1:0];
        unused_hi = ^shifted[ACC_W-1:DATA_WIDTH];

        acc_d = acc_q;
        if (upd_i) begin
            acc_d = sum;
        end else if (clr_i) begin
            acc_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/ads1281_result_avg.sv
// Block averager for ADS1281 filter results: averages 2^k samples, aborts on k change.
// Optional round-half-up via macro ADS1281_RESULT_AVG_ROUND_EN.
module ads1281_result_avg
    import ads1281_result_avg_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned MAX_LOG2   = MAX_LOG2_DEF
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  en_i,
    input  logic [2:0]            avg_log2_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  en_o,
    output logic                  abort_o
);

    localparam int unsigned CW = MAX_LOG2 + 1;

    state_t                state_q, state_d;
    logic [2:0]            k_q, k_d, k_eff, shift;
    logic [CW-1:0]         cnt_q, cnt_d, cnt_base;
    logic [DATA_WIDTH-1:0] data_q, data_d, result;
    logic                  en_q, en_d, abort_q, abort_d;
    logic                  abort, first, last, acc_upd, acc_clr;

    ads1281_result_avg_acc #(
        .DATA_WIDTH (DATA_WIDTH),
        .MAX_LOG2   (MAX_LOG2)
    ) u_acc (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .first_i  (first),
        .upd_i    (acc_upd),
        .clr_i    (acc_clr),
        .data_i   (data_i),
        .shift_i  (shift),
        .result_o (result)
    );

    always_comb begin
        k_eff    = (32'(avg_log2_i) > MAX_LOG2) ? 3'(MAX_LOG2) : avg_log2_i;
        abort    = (state_q == ACCUM) && (k_eff != k_q);
        first    = (state_q == IDLE) || abort;
        shift    = first ? k_eff : k_q;
        cnt_base = first ? '0 : cnt_q;
        last     = (cnt_base + CW'(1)) == (CW'(1) << shift);

        state_d = state_q;
        cnt_d   = cnt_q;
        k_d     = k_q;
        data_d  = data_q;
        en_d    = 1'b0;
        abort_d = abort;
        acc_upd = 1'b0;
        acc_clr = 1'b0;

        if (abort) begin
            state_d = IDLE;
            cnt_d   = '0;
            acc_clr = 1'b1;
        end
        if (en_i) begin
            if (last) begin
                state_d = IDLE;
                cnt_d   = '0;
                acc_clr = 1'b1;
                // A k=0 sample arriving with an abort is dropped so en_o never coincides with abort_o.
                if (!abort) begin
                    data_d = result;
                    en_d   = 1'b1;
                end
            end else begin
                acc_upd = 1'b1;
                cnt_d   = cnt_base + CW'(1);
                state_d = ACCUM;
                if (first) begin
                    k_d = k_eff;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            k_q     <= '0;
            data_q  <= '0;
            en_q    <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            k_q     <= k_d;
            data_q  <= data_d;
            en_q    <= en_d;
            abort_q <= abort_d;
        end
    end

    assign data_o  = data_q;
    assign en_o    = en_q;
    assign abort_o = abort_q;

endmodule

// File: tb/tb_ads1281_result_avg.sv
// Randomized self-checking bench for ads1281_result_avg against a queue-based block-average model.
module tb_ads1281_result_avg;

    localparam int DW = 24;
`ifdef ADS1281_RESULT_AVG_ROUND_EN
    localparam bit ROUND = 1'b1;
`else
    localparam bit ROUND = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en_i, en_o, abort_o;
    logic [2:0]    k_i;
    logic [DW-1:0] d_i, d_o;

    always #5 clk = ~clk;

    ads1281_result_avg #(
        .DATA_WIDTH (DW),
        .MAX_LOG2   (7)
    ) dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .data_i     (d_i),
        .en_i       (en_i),
        .avg_log2_i (k_i),
        .data_o     (d_o),
        .en_o       (en_o),
        .abort_o    (abort_o)
    );

    int            n_checks = 0;
    int            n_fail   = 0;
    int            blk[$];
    int            blk_k    = 0;
    logic [DW-1:0] m_data   = '0;
    logic          m_en     = 1'b0;
    logic          m_abort  = 1'b0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    // Expected outputs after one clock edge, from the block-averaging rules.
    task automatic model_step(input bit rst, input bit en, input int kin, input logic [DW-1:0] d);
        int     kc, nk, v;
        bit     aborted;
        longint sum;
        m_en    = 1'b0;
        m_abort = 1'b0;
        if (!rst) begin
            blk.delete();
            m_data = '0;
            return;
        end
        kc      = (kin > 7) ? 7 : kin;
        aborted = 1'b0;
        if (blk.size() > 0 && kc != blk_k) begin
            blk.delete();
            m_abort = 1'b1;
            aborted = 1'b1;
        end
        if (en) begin
            nk = (blk.size() == 0) ? kc : blk_k;
            v  = $signed(d);
            blk.push_back(v);
            if (blk.size() == (1 << nk)) begin
                if (!(aborted && nk == 0)) begin
                    sum = 0;
                    foreach (blk[i]) sum += blk[i];
                    if (ROUND && nk > 0) sum += longint'(1) << (nk - 1);
                    sum    = sum >>> nk;
                    m_data = sum[DW-1:0];
                    m_en   = 1'b1;
                end
                blk.delete();
            end else if (blk.size() == 1) begin
                blk_k = kc;
            end
        end
    endtask

    task automatic cyc(input bit rst, input bit en, input int k, input logic [DW-1:0] d);
        rst_n = rst;
        en_i  = en;
        k_i   = 3'(k);
        d_i   = d;
        @(posedge clk);
        model_step(rst, en, k, d);
        #1;
        check("en_o", 32'(en_o), 32'(m_en));
        check("abort_o", 32'(abort_o), 32'(m_abort));
        check("data_o", 32'(d_o), 32'(m_data));
    endtask

    initial begin
        int            k;
        logic [DW-1:0] d;
        rst_n = 1'b0; en_i = 1'b0; k_i = '0; d_i = '0;

        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        check("rst_data", 32'(d_o), 32'h0);
        check("rst_en", 32'(en_o), 32'h0);

        cyc(1, 1, 0, 24'h123456);
        check("pass_thru", 32'(d_o), 32'h123456);
        cyc(1, 0, 0, 0);

        cyc(1, 1, 2, 4); cyc(1, 1, 2, 5); cyc(1, 1, 2, 6); cyc(1, 1, 2, 7);
        check("avg4", 32'(d_o), ROUND ? 32'd6 : 32'd5);
        cyc(1, 0, 2, 0);

        cyc(1, 1, 1, -3); cyc(1, 1, 1, -4);
        check("avg_neg", 32'(d_o), ROUND ? 32'hFFFFFD : 32'hFFFFFC);

        for (int i = 0; i < 128; i++) cyc(1, 1, 7, 24'h7FFFFF);
        check("sat_pos", 32'(d_o), 32'h7FFFFF);
        for (int i = 0; i < 128; i++) cyc(1, 1, 7, 24'h800000);
        check("sat_neg", 32'(d_o), 32'h800000);

        cyc(1, 1, 2, 1); cyc(1, 1, 2, 2);
        cyc(1, 0, 1, 0);
        check("abort", 32'(abort_o), 32'h1);
        cyc(1, 1, 1, 10);
        check("abort_once", 32'(abort_o), 32'h0);
        cyc(1, 1, 1, 20);
        check("after_abort", 32'(d_o), 32'd15);

        cyc(1, 1, 2, 3); cyc(1, 1, 2, 3); cyc(1, 1, 2, 3);
        cyc(0, 0, 2, 0);
        check("rst_mid", 32'({d_o, en_o, abort_o}), 32'h0);
        cyc(1, 1, 2, 8); cyc(1, 1, 2, 8); cyc(1, 1, 2, 8); cyc(1, 1, 2, 8);
        check("after_rst", 32'(d_o), 32'd8);

        k = 3;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 59) == 0) k = $urandom_range(0, 7);
            case ($urandom_range(0, 7))
                0:       d = 24'h7FFFFF;
                1:       d = 24'h800000;
                default: d = DW'($urandom);
            endcase
            cyc(($urandom_range(0, 299) != 0), ($urandom_range(0, 9) < 7), k, d);
        end
        cyc(1, 0, k, 0);
        cyc(1, 0, k, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ads1281_result_avg.md
ADS1281_RESULT_AVG -- requirements
Module: ads1281_result_avg

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 24, meaning the width of the signed two's-complement filter result.
REQ-002 The block SHALL have parameter MAX_LOG2, default 7, meaning the largest averaging exponent, so at most 128 samples are averaged.
REQ-003 The block SHALL have port clk_i, input, 1 bit, the single system clock; all logic runs on its rising edge.
REQ-004 The block SHALL have port rst_n_i, input, 1 bit, the reset, which is synchronous and active-low.
REQ-005 The block SHALL have port data_i, input, DATA_WIDTH bits, the signed result from the upstream ads1281_filter.
REQ-006 The block SHALL have port en_i, input, 1 bit, a one-cycle strobe marking data_i as valid.
REQ-007 The block SHALL have port avg_log2_i, input, 3 bits, the exponent k; the block averages N = 2^k samples.
REQ-008 The block SHALL have port data_o, output, DATA_WIDTH bits, the signed averaged result, held between strobes.
REQ-009 The block SHALL have port en_o, output, 1 bit, a one-cycle strobe marking data_o as new.
REQ-010 The block SHALL have port abort_o, output, 1 bit, a one-cycle pulse when a partial block is discarded.

Function
REQ-011 The block SHALL clamp avg_log2_i values greater than MAX_LOG2 to MAX_LOG2.
REQ-012 The block SHALL implement a two-state FSM with states IDLE and ACCUM:
- IDLE means the sample count is 0.
- ACCUM means 1 to N-1 samples have been accumulated.
REQ-013 In IDLE with en_i=1 and k>0, the block SHALL latch k into k_q, load the accumulator with sign-extended data_i, set the count to 1 and go to ACCUM.
REQ-014 In ACCUM with en_i=1, the block SHALL add sign-extended data_i to the accumulator and increment the count.
REQ-015 When the accepted sample is the Nth sample, the block SHALL:
- register (acc + data_i) >>> k_q into data_o;
- assert en_o exactly one clock after that en_i;
- clear the accumulator and count;
- return to IDLE.
REQ-016 With k=0, each en_i SHALL produce en_o one cycle later with data_o equal to data_i (pass-through, latency 1).
REQ-017 The accumulator SHALL be DATA_WIDTH+MAX_LOG2 bits signed, so it cannot overflow and needs no saturation.
REQ-018 The block SHALL accept en_i on every clock cycle (back-to-back strobes) without losing samples.
REQ-019 If the clamped avg_log2_i differs from k_q while in ACCUM, the block SHALL:
- discard the partial block;
- pulse abort_o for one cycle;
- produce no en_o for that block;
- return to IDLE.
REQ-020 If a k change and en_i occur in the same cycle, the abort SHALL take effect and that sample SHALL start a new block using the new k.
REQ-021 data_o SHALL keep its last value when en_o=0; en_o and abort_o SHALL never both be asserted in the same cycle.

Reset
REQ-022 While rst_n_i=0 at a clock edge, the block SHALL:
- clear data_o, en_o and abort_o to 0;
- clear the accumulator and count to 0;
- set k_q to 0;
- set the FSM to IDLE.
REQ-023 A reset in mid-block SHALL discard the partial block silently, with no abort_o pulse.

Configuration
REQ-024 With macro ADS1281_RESULT_AVG_ROUND_EN defined, the block SHALL add 2^(k_q-1) to the sum before the arithmetic shift when k_q>0, giving round-half-up.
REQ-025 Without ADS1281_RESULT_AVG_ROUND_EN, the block SHALL truncate the result toward negative infinity using a plain arithmetic shift.

Structure
REQ-026 The shared package ads1281_result_avg_pkg SHALL hold:
- the DATA_WIDTH and MAX_LOG2 defaults;
- the accumulator-width constant;
- the FSM state enum typedef (IDLE, ACCUM).
REQ-027 The accumulate, round and shift datapath SHALL be a sub-module named ads1281_result_avg_acc; the FSM and strobe logic stay in the top level.

Verification
REQ-028 k=0, data_i=0x123456 with one en_i -> en_o one cycle later, data_o=0x123456.
REQ-029 k=2, samples 4,5,6,7 -> one en_o; data_o=5 when truncating, data_o=6 with ROUND_EN.
REQ-030 k=1, samples -3,-4 -> data_o=0xFFFFFC (-4) when truncating, 0xFFFFFD (-3) with ROUND_EN.
REQ-031 Saturation corners:
- k=7, 128 back-to-back samples of 0x7FFFFF -> data_o=0x7FFFFF.
- k=7, 128 back-to-back samples of 0x800000 -> data_o=0x800000.
REQ-032 k=2, two samples, then k set to 1 -> abort_o for one cycle and no en_o; then samples 10,20 -> data_o=15.
REQ-033 k=2, three samples, rst_n_i=0 for one cycle -> all outputs 0 and no abort_o; then samples 8,8,8,8 -> data_o=8.
